// File: rtl/sf_peak_det.sv
// sf_peak_det: threshold/hysteresis peak detector with hold-off and a single-entry record slot; SF_PEAK_TS_EN adds peak_ts.
module sf_peak_det #(
    parameter int DW      = 16,
    parameter int HYST    = 64,
    parameter int HOLDOFF = 8,
    parameter int TSW     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] thresh,
    input  logic          peak_ready,
    input  logic          clr_ovf,
    output logic          peak_valid,
    output logic [DW-1:0] peak_data,
`ifdef SF_PEAK_TS_EN
    output logic [TSW-1:0] peak_ts,
    output logic           peak_ovf
`else
    output logic           peak_ovf
`endif
);
    typedef enum logic [1:0] {REARM, IDLE, TRACK, HOLD} state_t;
    localparam int CW = $clog2(HOLDOFF + 1);
    localparam logic signed [DW:0] HYST_X = (DW+1)'(HYST);
    localparam logic [CW-1:0] CNT_INIT = CW'(HOLDOFF - 1);

    state_t state_q, state_d;
    logic signed [DW-1:0] run_max_q, run_max_d, din, thr;
    logic signed [DW:0] din_x, lim;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] peak_data_q, peak_data_d;
    logic peak_valid_q, peak_valid_d, peak_ovf_q, peak_ovf_d;
    logic upd, emit, load;

    assign din = $signed(in_data);
    assign thr = $signed(thresh);
    // one extra bit keeps run_max-HYST from wrapping near the negative limit
    assign din_x = {din[DW-1], din};
    assign lim = {run_max_q[DW-1], run_max_q} - HYST_X;
    assign peak_valid = peak_valid_q;
    assign peak_data = peak_data_q;
    assign peak_ovf = peak_ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        upd = 1'b0;
        emit = 1'b0;
        if (in_valid) begin
            case (state_q)
                REARM: if (din < thr) state_d = IDLE;
                IDLE: begin
                    if (din >= thr) begin
                        state_d = TRACK;
                        upd = 1'b1;
                    end
                end
                TRACK: begin
                    if (din > run_max_q) upd = 1'b1;
                    else if (din_x <= lim || din < thr) begin
                        emit = 1'b1;
                        state_d = HOLD;
                        cnt_d = CNT_INIT;
                    end
                end
                default: begin
                    cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
                    if (cnt_q == '0) state_d = REARM;
                end
            endcase
        end
        run_max_d = upd ? din : run_max_q;
        load = emit && (!peak_valid_q || peak_ready);
        peak_valid_d = load || (peak_valid_q && !peak_ready);
        peak_data_d = load ? run_max_q : peak_data_q;
        peak_ovf_d = (emit && peak_valid_q && !peak_ready) || (peak_ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REARM;
            cnt_q <= '0;
            run_max_q <= '0;
            peak_valid_q <= 1'b0;
            peak_data_q <= '0;
            peak_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            run_max_q <= run_max_d;
            peak_valid_q <= peak_valid_d;
            peak_data_q <= peak_data_d;
            peak_ovf_q <= peak_ovf_d;
        end
    end

`ifdef SF_PEAK_TS_EN
    logic [TSW-1:0] idx_q, idx_d, max_idx_q, max_idx_d, peak_ts_q, peak_ts_d;

    assign peak_ts = peak_ts_q;

    always_comb begin
        idx_d = in_valid ? idx_q + 1'b1 : idx_q;
        max_idx_d = upd ? idx_q : max_idx_q;
        peak_ts_d = load ? max_idx_q : peak_ts_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            max_idx_q <= '0;
            peak_ts_q <= '0;
        end else begin
            idx_q <= idx_d;
            max_idx_q <= max_idx_d;
            peak_ts_q <= peak_ts_d;
        end
    end
`endif
endmodule

// File: tb/tb_sf_peak_det.sv
// tb_sf_peak_det: directed vectors for sf_peak_det with hand-computed expectations.
module tb_sf_peak_det;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [15:0] thresh = '0;
    logic peak_ready = 1'b1;
    logic clr_ovf = 1'b0;
    logic peak_valid;
    logic [15:0] peak_data;
    logic peak_ovf;
`ifdef SF_PEAK_TS_EN
    logic [31:0] peak_ts;
`endif
    int n_vec = 0;
    int n_err = 0;

    sf_peak_det dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .thresh(thresh),
        .peak_ready(peak_ready),
        .clr_ovf(clr_ovf),
        .peak_valid(peak_valid),
        .peak_data(peak_data),
`ifdef SF_PEAK_TS_EN
        .peak_ts(peak_ts),
`endif
        .peak_ovf(peak_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        in_valid = 1'b1;
        in_data = 16'(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pd();
        return int'($signed(peak_data));
    endfunction

    initial begin
        // 1: reset state, REARM blocks a stream already above threshold
        do_reset();
        chk("rst_valid", int'(peak_valid), 0);
        chk("rst_data", pd(), 0);
        chk("rst_ovf", int'(peak_ovf), 0);
        thresh = 16'd50;
        send(100);
        send(100);
        send(10);
        chk("t1_no_peak", int'(peak_valid), 0);
        send(60);
        send(0);
        chk("t1_valid", int'(peak_valid), 1);
        chk("t1_data", pd(), 60);
`ifdef SF_PEAK_TS_EN
        chk("t1_ts", int'(peak_ts), 3);
`endif
        // 2: basic peak
        do_reset();
        thresh = 16'd100;
        send(0); send(150); send(300); send(500); send(480);
        chk("t2_no_emit_480", int'(peak_valid), 0);
        send(430);
        chk("t2_valid", int'(peak_valid), 1);
        chk("t2_data", pd(), 500);
`ifdef SF_PEAK_TS_EN
        chk("t2_ts", int'(peak_ts), 3);
`endif
        // 3: dip inside hysteresis
        do_reset();
        send(0); send(200); send(500); send(460);
        chk("t3_no_emit_460", int'(peak_valid), 0);
        send(520); send(450);
        chk("t3_valid", int'(peak_valid), 1);
        chk("t3_data", pd(), 520);
`ifdef SF_PEAK_TS_EN
        chk("t3_ts", int'(peak_ts), 4);
`endif
        // 4: hold-off of exactly 8 samples
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 0 : 600);
        chk("t4_hold_quiet", int'(peak_valid), 0);
        send(0); send(600); send(400);
        chk("t4_rearm_valid", int'(peak_valid), 1);
        chk("t4_rearm_data", pd(), 600);
        for (int i = 0; i < 8; i++) send(0);
        send(600); send(400);
        chk("t4_still_rearm", int'(peak_valid), 0);
        // 5: backpressure, drop, ovf set-wins and clear
        peak_ready = 1'b0;
        send(0); send(500); send(400);
        chk("t5_first", pd(), 500);
        for (int i = 0; i < 8; i++) send(0);
        send(0); send(700);
        clr_ovf = 1'b1;
        send(0);
        clr_ovf = 1'b0;
        chk("t5_held_valid", int'(peak_valid), 1);
        chk("t5_held_data", pd(), 500);
        chk("t5_ovf_set_wins", int'(peak_ovf), 1);
        peak_ready = 1'b1;
        idle();
        chk("t5_drained", int'(peak_valid), 0);
        chk("t5_ovf_sticky", int'(peak_ovf), 1);
        clr_ovf = 1'b1;
        idle();
        clr_ovf = 1'b0;
        chk("t5_ovf_clr", int'(peak_ovf), 0);
        // 6: negative limit, then async reset mid-TRACK
        do_reset();
        thresh = 16'd0;
        send(-1);
        thresh = 16'h8000;
        send(-32700);
        send(-32768);
        chk("t6_lim_valid", int'(peak_valid), 1);
        chk("t6_lim_data", pd(), -32700);
        do_reset();
        thresh = 16'd100;
        peak_ready = 1'b0;
        send(0); send(500); send(400);
        for (int i = 0; i < 8; i++) send(0);
        send(0); send(600);
        chk("t6_pre_rst_valid", int'(peak_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", int'(peak_valid), 0);
        chk("t6_async_data", pd(), 0);
        chk("t6_async_ovf", int'(peak_ovf), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        peak_ready = 1'b1;
        send(0); send(200); send(0);
        chk("t6_post_valid", int'(peak_valid), 1);
        chk("t6_post_data", pd(), 200);
`ifdef SF_PEAK_TS_EN
        chk("t6_post_ts", int'(peak_ts), 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
